vga_note_sched: RTL and testbench

Frame-synchronous scheduler between the note sources and the VGA keyboard picture generator. It arbitrates note-state updates from the live keyboard path and the autoplay path into one staging register. It commits the staged vector to the picture generator's `note` input only at a frame boundary, which prevents tearing. A per-key hold timer keeps every tapped key lit for at least `HOLD_FRAMES` frames.

---
 rtl/vga_note_sched_if.sv | 64 ++++++
 rtl/vga_note_sched.sv | 180 ++++++++++++++++++
 tb/tb_vga_note_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_note_sched_if.sv
// ----------------------------------------------------------------------------
// vga_note_sched_if
//
// Purpose:
//   Bundles the signals between the note sources, the VGA timing controller
//   and the picture generator on one side, and the frame-synchronous note
//   scheduler on the other side.
//
// Signals:
//   vsync        timing controller -> scheduler, active-low vertical sync
//   live_req     live keyboard update strobe
//   live_note    live key state, valid while live_req is high
//   live_gnt     scheduler -> live source, one-cycle acknowledge
//   play_req     autoplay update strobe
//   play_note    autoplay key state, valid while play_req is high
//   play_gnt     scheduler -> autoplay source, one-cycle acknowledge
//   note_out     committed display vector for the picture generator
//   src_out      source of the last committed vector (00 none, 01 live, 10 play)
//   commit_pulse one-cycle pulse when note_out takes a new value
//
// Modports:
//   master  the environment side (sources, timing controller, display)
//   slave   the scheduler
// ----------------------------------------------------------------------------
interface vga_note_sched_if #(
    parameter int NUM_KEYS = 8
);
    logic                vsync;
    logic                live_req;
    logic [NUM_KEYS-1:0] live_note;
    logic                live_gnt;
    logic                play_req;
    logic [NUM_KEYS-1:0] play_note;
    logic                play_gnt;
    logic [NUM_KEYS-1:0] note_out;
    logic [1:0]          src_out;
    logic                commit_pulse;

    modport master (
        output vsync,
        output live_req,
        output live_note,
        output play_req,
        output play_note,
        input  live_gnt,
        input  play_gnt,
        input  note_out,
        input  src_out,
        input  commit_pulse
    );

    modport slave (
        input  vsync,
        input  live_req,
        input  live_note,
        input  play_req,
        input  play_note,
        output live_gnt,
        output play_gnt,
        output note_out,
        output src_out,
        output commit_pulse
    );
endinterface

// File: rtl/vga_note_sched.sv
// ----------------------------------------------------------------------------
// vga_note_sched
//
// Purpose:
//   Frame-synchronous scheduler between the note sources and the VGA keyboard
//   picture generator. Live keyboard and autoplay updates are arbitrated
//   (live wins) into a single staging register. The staged vector is only
//   committed to note_out on the falling edge of vsync, so the picture never
//   tears mid-frame. A per-key hold counter keeps every staged key lit for at
//   least HOLD_FRAMES frames.
//
// Parameters:
//   NUM_KEYS     width of every note vector
//   HOLD_FRAMES  minimum frames a staged key stays lit (1..255)
//
// Ports:
//   vga_clk      pixel clock, the only clock
//   sys_rst_n    asynchronous active-low reset
//   bus          vga_note_sched_if slave modport (vsync, live/play request
//                and grant, note_out, src_out, commit_pulse)
// ----------------------------------------------------------------------------
module vga_note_sched #(
    parameter int NUM_KEYS    = 8,
    parameter int HOLD_FRAMES = 6
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    vga_note_sched_if.slave   bus
);

    localparam int              HOLD_W      = 8;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_FRAMES - 1);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_LIVE = 2'b01;
    localparam logic [1:0] SRC_PLAY = 2'b10;

    typedef enum logic {
        RUN    = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                vs_d;
    logic                frame_edge;
    logic                commit_en;

    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] pending_d;
    logic [1:0]          pending_src;
    logic [1:0]          pending_src_d;
    logic                live_gnt_q;
    logic                live_gnt_d;
    logic                play_gnt_q;
    logic                play_gnt_d;

    logic [HOLD_W-1:0]   hold   [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] lit_d;

    logic [NUM_KEYS-1:0] note_q;
    logic [1:0]          src_q;
    logic                commit_q;

    // One key's commit step: returns {lit, next_hold}. A staged key reloads
    // the counter (restart, never accumulate); an unstaged key with a running
    // counter stays lit and counts down; the counter saturates at zero.
    function automatic logic [HOLD_W:0] hold_step(input logic              staged,
                                                  input logic [HOLD_W-1:0] cnt);
        if (staged) begin
            return {1'b1, HOLD_RELOAD};
        end else if (cnt != '0) begin
            return {1'b1, cnt - HOLD_W'(1)};
        end else begin
            return {1'b0, cnt};
        end
    endfunction

    // vs_d resets to 0, so a vsync already low at reset release is not
    // mistaken for a frame boundary.
    assign frame_edge = vs_d & ~bus.vsync;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame_edge during COMMIT cannot happen with legal VGA timing and is
    // deliberately ignored.
    always_comb begin
        state_d   = state_q;
        commit_en = 1'b0;
        case (state_q)
            RUN: begin
                if (frame_edge) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit_en = 1'b1;
                state_d   = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------- arbitration
    // Runs in every state, including COMMIT: a capture during COMMIT lands in
    // pending after the commit has sampled it, so it belongs to the next frame.
    always_comb begin
        pending_d     = pending;
        pending_src_d = pending_src;
        live_gnt_d    = 1'b0;
        play_gnt_d    = 1'b0;
        if (bus.live_req) begin
            pending_d     = bus.live_note;
            pending_src_d = SRC_LIVE;
            live_gnt_d    = 1'b1;
        end else if (bus.play_req) begin
            pending_d     = bus.play_note;
            pending_src_d = SRC_PLAY;
            play_gnt_d    = 1'b1;
        end
    end

    // ---------------------------------------------------------------- commit datapath
    always_comb begin
        hold_d = hold;
        lit_d  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            {lit_d[i], hold_d[i]} = hold_step(pending[i], hold[i]);
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_d        <= 1'b0;
            pending     <= '0;
            pending_src <= SRC_NONE;
            live_gnt_q  <= 1'b0;
            play_gnt_q  <= 1'b0;
            note_q      <= '0;
            src_q       <= SRC_NONE;
            commit_q    <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            vs_d        <= bus.vsync;
            pending     <= pending_d;
            pending_src <= pending_src_d;
            live_gnt_q  <= live_gnt_d;
            play_gnt_q  <= play_gnt_d;
            commit_q    <= commit_en;
            if (commit_en) begin
                note_q <= lit_d;
                src_q  <= pending_src;
                for (int i = 0; i < NUM_KEYS; i++) begin
                    hold[i] <= hold_d[i];
                end
            end
        end
    end

    assign bus.note_out     = note_q;
    assign bus.src_out      = src_q;
    assign bus.commit_pulse = commit_q;
    assign bus.live_gnt     = live_gnt_q;
    assign bus.play_gnt     = play_gnt_q;

endmodule

// File: tb/tb_vga_note_sched.sv
// ----------------------------------------------------------------------------
// tb_vga_note_sched
//
// Directed testbench for vga_note_sched (NUM_KEYS=8, HOLD_FRAMES=6).
// Inputs change 1 time unit after the rising clock edge and outputs are
// sampled at that same point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_vga_note_sched;

    localparam int NUM_KEYS    = 8;
    localparam int HOLD_FRAMES = 6;

    logic vga_clk;
    logic sys_rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    vga_note_sched_if #(.NUM_KEYS(NUM_KEYS)) bus ();

    vga_note_sched #(
        .NUM_KEYS   (NUM_KEYS),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stage one update from a source for a single cycle and check its grant.
    task automatic stage(input bit use_live, input logic [7:0] note, input string tag);
        if (use_live) begin
            bus.live_req  = 1'b1;
            bus.live_note = note;
        end else begin
            bus.play_req  = 1'b1;
            bus.play_note = note;
        end
        tick();
        chk({tag, "_live_gnt"}, {31'd0, bus.live_gnt}, {31'd0, use_live});
        chk({tag, "_play_gnt"}, {31'd0, bus.play_gnt}, {31'd0, !use_live});
        bus.live_req = 1'b0;
        bus.play_req = 1'b0;
        tick();
        chk({tag, "_gnt_drop"}, {30'd0, bus.live_gnt, bus.play_gnt}, 32'd0);
    endtask

    // One frame boundary: vsync falls, the commit lands two cycles later,
    // then vsync returns high and note_out must hold its value.
    task automatic do_frame(input logic [7:0] exp_note, input logic [1:0] exp_src,
                            input string tag);
        bus.vsync = 1'b0;
        tick();
        chk({tag, "_pulse_T1"}, {31'd0, bus.commit_pulse}, 32'd0);
        tick();
        chk({tag, "_pulse"}, {31'd0, bus.commit_pulse}, 32'd1);
        chk({tag, "_note"},  {24'd0, bus.note_out},     {24'd0, exp_note});
        chk({tag, "_src"},   {30'd0, bus.src_out},      {30'd0, exp_src});
        bus.vsync = 1'b1;
        tick();
        chk({tag, "_pulse_off"}, {31'd0, bus.commit_pulse}, 32'd0);
        tick();
        chk({tag, "_note_hold"}, {24'd0, bus.note_out}, {24'd0, exp_note});
    endtask

    initial begin
        bus.vsync     = 1'b0;
        bus.live_req  = 1'b0;
        bus.live_note = '0;
        bus.play_req  = 1'b0;
        bus.play_note = '0;
        sys_rst_n     = 1'b0;
        tick();
        tick();
        chk("rst_note", {24'd0, bus.note_out}, 32'd0);
        chk("rst_src",  {30'd0, bus.src_out}, 32'd0);
        chk("rst_pulse", {31'd0, bus.commit_pulse}, 32'd0);
        chk("rst_gnt",  {30'd0, bus.live_gnt, bus.play_gnt}, 32'd0);

        // Release with vsync low: no spurious commit.
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rel_low_pulse", {31'd0, bus.commit_pulse}, 32'd0);
        end
        bus.vsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_high_pulse", {31'd0, bus.commit_pulse}, 32'd0);
            chk("rel_high_note", {24'd0, bus.note_out}, 32'd0);
        end
        do_frame(8'h00, 2'b00, "f0_empty");

        // Live tap 0x05 then 0x00: bits 0 and 2 lit for exactly 6 commits.
        stage(1'b1, 8'h05, "live05");
        do_frame(8'h05, 2'b01, "hold_c1");
        stage(1'b1, 8'h00, "live00");
        do_frame(8'h05, 2'b01, "hold_c2");
        do_frame(8'h05, 2'b01, "hold_c3");
        do_frame(8'h05, 2'b01, "hold_c4");
        do_frame(8'h05, 2'b01, "hold_c5");
        do_frame(8'h05, 2'b01, "hold_c6");
        do_frame(8'h00, 2'b01, "hold_c7_off");

        // Simultaneous live/play: live wins, play not queued.
        bus.live_req  = 1'b1;
        bus.live_note = 8'h01;
        bus.play_req  = 1'b1;
        bus.play_note = 8'h80;
        tick();
        chk("arb_live_gnt", {31'd0, bus.live_gnt}, 32'd1);
        chk("arb_play_gnt", {31'd0, bus.play_gnt}, 32'd0);
        bus.live_req = 1'b0;
        tick();
        chk("arb_play_gnt2", {31'd0, bus.play_gnt}, 32'd1);
        chk("arb_live_gnt2", {31'd0, bus.live_gnt}, 32'd0);
        bus.play_req = 1'b0;
        tick();
        // Play captured after live in the same frame overwrites it.
        do_frame(8'h80, 2'b10, "arb_last_wins");

        // Re-run the directed case with a frame in between.
        stage(1'b1, 8'h01, "live01");
        do_frame(8'h81, 2'b01, "arb_c1");
        stage(1'b0, 8'h80, "play80");
        do_frame(8'h81, 2'b10, "arb_c2");

        // Holds now: key0=4, key7=5. Play request in the COMMIT cycle.
        bus.vsync = 1'b0;
        tick();
        bus.play_req  = 1'b1;
        bus.play_note = 8'h10;
        tick();
        chk("cmt_req_pulse", {31'd0, bus.commit_pulse}, 32'd1);
        chk("cmt_req_note",  {24'd0, bus.note_out}, 32'h81);
        chk("cmt_req_src",   {30'd0, bus.src_out}, 32'd2);
        chk("cmt_req_gnt",   {31'd0, bus.play_gnt}, 32'd1);
        bus.play_req = 1'b0;
        bus.vsync    = 1'b1;
        tick();
        chk("cmt_req_gnt_off", {31'd0, bus.play_gnt}, 32'd0);
        // key0 3->2, key7 5->4, key4 new.
        do_frame(8'h91, 2'b10, "cmt_next");

        // Holds: key0=2, key7=4, key4=5. Key 3 tap, release, re-press at hold=2.
        stage(1'b1, 8'h08, "k3_a");
        do_frame(8'h99, 2'b01, "k3_c1");
        stage(1'b1, 8'h00, "k3_rel");
        do_frame(8'h99, 2'b01, "k3_c2");
        do_frame(8'h98, 2'b01, "k3_c3");
        do_frame(8'h98, 2'b01, "k3_c4");
        stage(1'b1, 8'h08, "k3_b");
        do_frame(8'h18, 2'b01, "k3_c5_reload");
        stage(1'b1, 8'h00, "k3_rel2");
        do_frame(8'h08, 2'b01, "k3_c6");
        do_frame(8'h08, 2'b01, "k3_c7");
        do_frame(8'h08, 2'b01, "k3_c8");
        do_frame(8'h08, 2'b01, "k3_c9");
        do_frame(8'h08, 2'b01, "k3_c10");
        do_frame(8'h00, 2'b01, "k3_c11_off");

        // Reset in the middle of a hold sequence.
        stage(1'b1, 8'h05, "mid_a");
        do_frame(8'h05, 2'b01, "mid_c1");
        bus.live_req  = 1'b1;
        bus.live_note = 8'h02;
        tick();
        chk("mid_gnt_pre", {31'd0, bus.live_gnt}, 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_note", {24'd0, bus.note_out}, 32'd0);
        chk("mid_rst_src",  {30'd0, bus.src_out}, 32'd0);
        chk("mid_rst_gnt",  {30'd0, bus.live_gnt, bus.play_gnt}, 32'd0);
        bus.live_req = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        tick();
        chk("mid_rel_pulse", {31'd0, bus.commit_pulse}, 32'd0);
        stage(1'b0, 8'h40, "mid_b");
        do_frame(8'h40, 2'b10, "mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
